// File: rtl/bench_mon_pkg.sv
// Shared state type and default widths for the ring round-trip latency monitor.
package bench_mon_pkg;

   typedef enum logic [2:0] {IDLE, ARM, MEASURE, DONE, TIMEOUT} bench_mon_state_t;

   localparam int DEF_CNT_W       = 32;
   localparam int DEF_SUM_W       = 48;
   localparam int DEF_EV_W        = 16;
   localparam int DEF_TIMEOUT_CYC = 1000000;

endpackage

// File: rtl/bench_lat_stats.sv
// Latency statistics: count, min, max and saturating sum of recorded intervals.
module bench_lat_stats
   import bench_mon_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int SUM_W = DEF_SUM_W,
   parameter int EV_W  = DEF_EV_W
) (
   input  logic             i_clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             rec,
   input  logic [CNT_W-1:0] ivl,
   output logic [EV_W-1:0]  ev_cnt,
   output logic [CNT_W-1:0] lat_min,
   output logic [CNT_W-1:0] lat_max,
   output logic [SUM_W-1:0] lat_sum
);

   localparam int SUM_X_W = SUM_W + 1;

   logic [EV_W-1:0]  ev_cnt_q, ev_cnt_d;
   logic [CNT_W-1:0] lat_min_q, lat_min_d;
   logic [CNT_W-1:0] lat_max_q, lat_max_d;
   logic [SUM_W-1:0] lat_sum_q, lat_sum_d;
   logic [SUM_W:0]   sum_ext;

   always_comb begin
      // NOTE: every always_comb output is given a default first so no path infers a latch.
      ev_cnt_d  = ev_cnt_q;
      lat_min_d = lat_min_q;
      lat_max_d = lat_max_q;
      lat_sum_d = lat_sum_q;
      sum_ext   = {1'b0, lat_sum_q} + SUM_X_W'(ivl);
      if (clr) begin
         ev_cnt_d  = '0;
         lat_min_d = '1;
         lat_max_d = '0;
         lat_sum_d = '0;
      end else if (rec) begin
         ev_cnt_d = ev_cnt_q + 1'b1;
         if (ivl < lat_min_q) lat_min_d = ivl;
         if (ivl > lat_max_q) lat_max_d = ivl;
         // Carry out of the widened add means the sum pinned at all-ones.
         lat_sum_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
      end
   end

   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
      if (!reset_n) begin
         ev_cnt_q  <= '0;
         lat_min_q <= '1;
         lat_max_q <= '0;
         lat_sum_q <= '0;
      end else begin
         ev_cnt_q  <= ev_cnt_d;
         lat_min_q <= lat_min_d;
         lat_max_q <= lat_max_d;
         lat_sum_q <= lat_sum_d;
      end
   end

   assign ev_cnt  = ev_cnt_q;
   assign lat_min = lat_min_q;
   assign lat_max = lat_max_q;
   assign lat_sum = lat_sum_q;

endmodule

// File: rtl/bench_event_monitor.sv
// Measures ring round-trip latency from token transitions, with a stall watchdog.
module bench_event_monitor
   import bench_mon_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int SUM_W       = DEF_SUM_W,
   parameter int EV_W        = DEF_EV_W,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic             i_clk,
   input  logic             reset_n,
   input  logic             benchmark_event,
   input  logic             start,
   input  logic [EV_W-1:0]  n_events,
   output logic             busy,
   output logic             done,
   output logic             timeout_err,
   output logic [EV_W-1:0]  ev_cnt,
   output logic [CNT_W-1:0] lat_min,
   output logic [CNT_W-1:0] lat_max,
   output logic [SUM_W-1:0] lat_sum
);

   localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYC);

   bench_mon_state_t state_q, state_d;
   logic             ev_q, ev_d;
   logic [EV_W-1:0]  tgt_q, tgt_d;
   logic [CNT_W-1:0] ivl_q, ivl_d, ivl_inc;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             to_q, to_d;
   logic             ev_pulse, expired, clr, rec;

   always_comb begin
      ev_d     = benchmark_event;
      ev_pulse = benchmark_event ^ ev_q;
      ivl_inc  = (ivl_q == '1) ? ivl_q : ivl_q + 1'b1;
      expired  = (ivl_q >= TO_LIM);
      state_d  = state_q;
      tgt_d    = tgt_q;
      ivl_d    = ivl_q;
      clr      = 1'b0;
      rec      = 1'b0;
      unique case (state_q)
         IDLE, DONE, TIMEOUT: begin
            if (start) begin
               clr     = 1'b1;
               tgt_d   = n_events;
               ivl_d   = '0;
               state_d = (n_events == '0) ? DONE : ARM;
            end
         end
         ARM: begin
            // The first transition only fixes the phase; nothing is recorded.
            if (ev_pulse) begin
               ivl_d   = CNT_W'(1);
               state_d = MEASURE;
            end else if (expired) begin
               state_d = TIMEOUT;
            end else begin
               ivl_d = ivl_inc;
            end
         end
         MEASURE: begin
            // An event beats a simultaneous watchdog expiry.
            if (ev_pulse) begin
               rec   = 1'b1;
               ivl_d = CNT_W'(1);
               if (ev_cnt == tgt_q - 1'b1) state_d = DONE;
            end else if (expired) begin
               state_d = TIMEOUT;
            end else begin
               ivl_d = ivl_inc;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == ARM) || (state_d == MEASURE);
      done_d = (state_d == DONE) || (state_d == TIMEOUT);
      to_d   = (state_d == TIMEOUT);
   end

   always_ff @(posedge i_clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ev_q    <= 1'b0;
         tgt_q   <= '0;
         ivl_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ev_q    <= ev_d;
         tgt_q   <= tgt_d;
         ivl_q   <= ivl_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         to_q    <= to_d;
      end
   end

   bench_lat_stats #(
      .CNT_W(CNT_W),
      .SUM_W(SUM_W),
      .EV_W (EV_W)
   ) u_stats (
      .i_clk  (i_clk),
      .reset_n(reset_n),
      .clr    (clr),
      .rec    (rec),
      .ivl    (ivl_q),
      .ev_cnt (ev_cnt),
      .lat_min(lat_min),
      .lat_max(lat_max),
      .lat_sum(lat_sum)
   );

   assign busy        = busy_q;
   assign done        = done_q;
   assign timeout_err = to_q;

endmodule

// File: tb/tb_bench_event_monitor.sv
// Directed bench for bench_event_monitor: cycle-stamp model compared every cycle plus literal checks.
module tb_bench_event_monitor;

   localparam int CNT_W = 32;
   localparam int SUM_W = 48;
   localparam int EV_W  = 16;
   localparam int TO    = 50;
   localparam logic [63:0] MIN_INIT = 64'h0000_0000_FFFF_FFFF;

   logic             i_clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             benchmark_event = 1'b0;
   logic             start = 1'b0;
   logic [EV_W-1:0]  n_events = '0;
   logic             busy, done, timeout_err;
   logic [EV_W-1:0]  ev_cnt;
   logic [CNT_W-1:0] lat_min, lat_max;
   logic [SUM_W-1:0] lat_sum;

   bench_event_monitor #(
      .CNT_W(CNT_W), .SUM_W(SUM_W), .EV_W(EV_W), .TIMEOUT_CYC(TO)
   ) dut (
      .i_clk          (i_clk),
      .reset_n        (reset_n),
      .benchmark_event(benchmark_event),
      .start          (start),
      .n_events       (n_events),
      .busy           (busy),
      .done           (done),
      .timeout_err    (timeout_err),
      .ev_cnt         (ev_cnt),
      .lat_min        (lat_min),
      .lat_max        (lat_max),
      .lat_sum        (lat_sum)
   );

   initial forever #5 i_clk = ~i_clk;

   int total = 0;
   int bad   = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: stamps each detected transition with its cycle number and keeps the
   // list of recorded intervals; outputs are folded from that list.
   typedef enum int {M_IDLE, M_ARM, M_MEAS, M_DONE, M_TO} m_phase_t;
   m_phase_t m_phase = M_IDLE;
   int       cyc = 0;
   int       ref_c = 0;
   int       m_tgt = 0;
   int       ivls[$];
   logic     m_prev = 1'b0;
   logic     m_ev;

   always @(posedge i_clk) begin
      m_ev = benchmark_event ^ m_prev;
      if (!reset_n) begin
         m_phase = M_IDLE;
         ivls.delete();
         m_prev  = 1'b0;
      end else begin
         m_prev = benchmark_event;
         case (m_phase)
            M_IDLE, M_DONE, M_TO: begin
               if (start) begin
                  ivls.delete();
                  m_tgt   = int'(n_events);
                  ref_c   = cyc + 1;
                  m_phase = (m_tgt == 0) ? M_DONE : M_ARM;
               end
            end
            M_ARM: begin
               if (m_ev) begin
                  ref_c   = cyc;
                  m_phase = M_MEAS;
               end else if (cyc - ref_c >= TO) begin
                  m_phase = M_TO;
               end
            end
            M_MEAS: begin
               if (m_ev) begin
                  ivls.push_back(cyc - ref_c);
                  ref_c = cyc;
                  if (ivls.size() == m_tgt) m_phase = M_DONE;
               end else if (cyc - ref_c >= TO) begin
                  m_phase = M_TO;
               end
            end
            default: ;
         endcase
      end
      cyc++;
   end

   logic [63:0] e_min, e_max, e_sum;

   always @(negedge i_clk) begin
      if (cmp_en) begin
         e_min = MIN_INIT;
         e_max = '0;
         e_sum = '0;
         foreach (ivls[i]) begin
            if (64'(ivls[i]) < e_min) e_min = 64'(ivls[i]);
            if (64'(ivls[i]) > e_max) e_max = 64'(ivls[i]);
            e_sum += 64'(ivls[i]);
         end
         check("cyc_busy", busy, (m_phase == M_ARM) || (m_phase == M_MEAS));
         check("cyc_done", done, (m_phase == M_DONE) || (m_phase == M_TO));
         check("cyc_timeout_err", timeout_err, m_phase == M_TO);
         check("cyc_ev_cnt", ev_cnt, ivls.size());
         check("cyc_lat_min", lat_min, e_min);
         check("cyc_lat_max", lat_max, e_max);
         check("cyc_lat_sum", lat_sum, e_sum);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic toggle();
      benchmark_event = ~benchmark_event;
   endtask

   task automatic pulse_start(input int n);
      start    = 1'b1;
      n_events = EV_W'(n);
      tick(1);
      start    = 1'b0;
   endtask

   initial begin
      int k;
      tick(1);
      cmp_en = 1'b1;
      tick(1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_timeout", timeout_err, 0);
      check("rst_ev_cnt", ev_cnt, 0);
      check("rst_lat_min", lat_min, MIN_INIT);
      check("rst_lat_max", lat_max, 0);
      check("rst_lat_sum", lat_sum, 0);
      reset_n = 1'b1;
      tick(2);

      // Steady toggles every 5 cycles, four intervals.
      pulse_start(4);
      check("t1_busy_after_start", busy, 1);
      toggle();
      for (int i = 0; i < 4; i++) begin
         tick(5);
         toggle();
      end
      tick(1);
      check("t1_ev_cnt", ev_cnt, 4);
      check("t1_lat_min", lat_min, 5);
      check("t1_lat_max", lat_max, 5);
      check("t1_lat_sum", lat_sum, 20);
      check("t1_done", done, 1);
      check("t1_timeout", timeout_err, 0);
      check("t1_busy_low", busy, 0);

      // Uneven gaps 3, 7, 2; restart straight out of DONE.
      pulse_start(3);
      toggle();
      tick(3); toggle();
      tick(7); toggle();
      tick(2); toggle();
      tick(1);
      check("t2_lat_min", lat_min, 2);
      check("t2_lat_max", lat_max, 7);
      check("t2_lat_sum", lat_sum, 12);
      check("t2_ev_cnt", ev_cnt, 3);

      // One interval of 4, then the ring stalls.
      pulse_start(5);
      toggle();
      tick(4); toggle();
      k = 0;
      while (k < 200 && timeout_err !== 1'b1) begin
         tick(1);
         k++;
      end
      check("t3_timeout_latency", k, 51);
      check("t3_ev_cnt", ev_cnt, 1);
      check("t3_lat_sum", lat_sum, 4);
      check("t3_done", done, 1);

      // Zero-length request, then a start ignored mid-measurement.
      pulse_start(0);
      check("t4_done", done, 1);
      check("t4_timeout_clr", timeout_err, 0);
      check("t4_ev_cnt", ev_cnt, 0);
      check("t4_lat_min", lat_min, MIN_INIT);
      pulse_start(3);
      toggle();
      tick(2); toggle();
      tick(1);
      pulse_start(1);
      check("t4_ign_busy", busy, 1);
      check("t4_ign_done", done, 0);
      check("t4_ign_ev_cnt", ev_cnt, 1);
      tick(1); toggle();
      tick(3); toggle();
      tick(1);
      check("t4_ev_cnt_final", ev_cnt, 3);
      check("t4_lat_sum", lat_sum, 8);
      check("t4_done_final", done, 1);

      // One-cycle reset in the middle of a measurement.
      pulse_start(4);
      toggle();
      tick(3); toggle();
      tick(3);
      reset_n = 1'b0;
      tick(1);
      reset_n = 1'b1;
      check("t5_busy", busy, 0);
      check("t5_done", done, 0);
      check("t5_ev_cnt", ev_cnt, 0);
      check("t5_lat_min", lat_min, MIN_INIT);
      check("t5_lat_max", lat_max, 0);
      check("t5_lat_sum", lat_sum, 0);
      pulse_start(2);
      toggle();
      tick(6); toggle();
      tick(6); toggle();
      tick(1);
      check("t5_lat_sum_new", lat_sum, 12);
      check("t5_done_new", done, 1);

      // Back-to-back transitions, final one lands exactly on watchdog expiry.
      pulse_start(3);
      toggle();
      tick(1); toggle();
      tick(1); toggle();
      tick(TO); toggle();
      tick(1);
      check("t6_done", done, 1);
      check("t6_timeout", timeout_err, 0);
      check("t6_ev_cnt", ev_cnt, 3);
      check("t6_lat_min", lat_min, 1);
      check("t6_lat_max", lat_max, TO);
      check("t6_lat_sum", lat_sum, TO + 2);

      tick(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
